reg_file_32x64: RTL and testbench
=================================

// Module: reg_file_32x64
// PURPOSE
//  Architectural register file for the datapath: 32 registers x WIDTH bits, one
//  synchronous write port, two combinational read ports (Rn/Rm operands).
//  Register ZERO_REG is hardwired to zero (XZR).
//  Upstream of the per-bit 32:1 read-select muxes. Built as: 5:32 write decoder,
//  32 enabled D-flop registers, two read-select mux banks, optional write->read bypass.
// PARAMETERS
//  WIDTH     64  data width of each register and of all data ports
//  ZERO_REG  31  index of the read-as-zero, write-ignored register
//  BYPASS    1   1 = same-cycle write data forwarded to matching read port; 0 = no forwarding
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst_n      in   1      asynchronous active-low reset
//  wr_en      in   1      write enable
//  wr_addr    in   5      write register index
//  wr_data    in   WIDTH  write data
//  rd_addr_a  in   5      read port A index
//  rd_addr_b  in   5      read port B index
//  rd_data_a  out  WIDTH  read port A data (combinational)
//  rd_data_b  out  WIDTH  read port B data (combinational)
// BEHAVIOUR
//  Clock/reset: one clock. Reset is asynchronous and active-low.
//  Reset:
//  - rst_n=0 clears all 32 registers to 0 immediately, independent of clk.
//  - While rst_n=0, rd_data_a/b = 0 for every address.
//  - With BYPASS=1, forwarding is suppressed during reset.
//  - A posedge with rst_n=0 performs no write, even if wr_en=1.
//  - Reset asserted mid-operation discards any write not yet clocked.
//  - First write occurs on the first posedge with rst_n=1.
//  Write:
//  - At posedge, if wr_en=1 and wr_addr!=ZERO_REG, then reg[wr_addr] <= wr_data.
//  - wr_en=0 leaves all registers unchanged.
//  - Writes to ZERO_REG are silently dropped; no other register changes.
//  Read:
//  - rd_data_x = reg[rd_addr_x]; combinational, zero cycle latency from address change.
//  - rd_addr_x==ZERO_REG always returns 0, overriding the bypass.
//  - Written data is visible on the read ports from the cycle after the write posedge.
//  Bypass (BYPASS=1 only):
//  - If wr_en=1, wr_addr==rd_addr_x, wr_addr!=ZERO_REG and rst_n=1,
//    then rd_data_x = wr_data in the same cycle, before the edge.
//  - Applies to A and B independently; both ports may forward simultaneously.
//  - With BYPASS=0, the read returns the old value until after the edge.
//  Simultaneous events:
//  - A and B reading the same address return identical data.
//  - Read and write of the same address in one cycle: result is governed by BYPASS as above.
//  - No illegal address exists: all 5-bit values are valid.
//  Structure: write decoder gated by wr_en. Per-register load enable, recirculating when
//  not enabled (no clock gating). Read muxes one per bit per port; ZERO_REG output forced to 0.
// TESTING
//  1 Reset: write 0xDEAD_BEEF_0000_0001 to X5; pulse rst_n low between edges
//    -> rd_data_a(X5)=0 immediately; all 32 addresses read 0 after release.
//  2 Write/read: write X0..X30 with value 0x1111_1111_1111_1111*i, sweep A and B over all
//    addresses -> each returns its value; X31 returns 0.
//  3 Zero reg: wr_en=1, wr_addr=31, wr_data=all-ones -> X31 reads 0; X30 unchanged.
//  4 Bypass: BYPASS=1, X7=0x10; same cycle wr_addr=7, wr_data=0x20, rd_addr_a=7
//    -> rd_data_a=0x20 before edge. BYPASS=0 -> 0x10 before edge, 0x20 after.
//  5 wr_en gating: wr_en=0, wr_addr=3, wr_data=0xFF over 4 edges -> X3 keeps prior value 0x33.
//  6 Reset vs write: rst_n=0 across posedge with wr_en=1, X9, 0x99
//    -> X9=0 after rst_n release; no write occurred.

Source files
------------

// File: rtl/reg_file_32x64.sv
// ----------------------------------------------------------------------------
// reg_file_32x64
// Architectural register file: 32 x WIDTH registers, one synchronous write
// port and two combinational read ports (Rn/Rm operands). Register ZERO_REG
// reads as zero and ignores writes (XZR).
//
// Ports
//   clk        in   1      clock, state updates on posedge
//   rst_n      in   1      asynchronous active-low reset, clears all registers
//   wr_en      in   1      write enable
//   wr_addr    in   5      write register index
//   wr_data    in   WIDTH  write data
//   rd_addr_a  in   5      read port A index
//   rd_addr_b  in   5      read port B index
//   rd_data_a  out  WIDTH  read port A data (combinational)
//   rd_data_b  out  WIDTH  read port B data (combinational)
// ----------------------------------------------------------------------------
module reg_file_32x64 #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ZERO_REG = 31,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);

    localparam int unsigned NUM_REGS = 32;
    localparam logic [4:0]  ZERO_IDX = 5'(ZERO_REG);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_dec;
    logic                fwd_a;
    logic                fwd_b;

    // 5:32 write decoder gated by wr_en; the zero register never loads
    always_comb begin
        wr_dec = '0;
        if (wr_en && (wr_addr != ZERO_IDX)) begin
            wr_dec = NUM_REGS'(1) << wr_addr;
        end
    end

    // Per-register load enable, recirculating otherwise
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_dec[i]) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Register array with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Same-cycle forward: the decoder already excludes the zero register
    always_comb begin
        fwd_a = BYPASS && rst_n && wr_en && (wr_addr == rd_addr_a) && (wr_addr != ZERO_IDX);
        fwd_b = BYPASS && rst_n && wr_en && (wr_addr == rd_addr_b) && (wr_addr != ZERO_IDX);
    end

    // Read port A: zero register and reset force 0 over the bypass
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (fwd_a) begin
            rd_data_a = wr_data;
        end
        if (!rst_n || (rd_addr_a == ZERO_IDX)) begin
            rd_data_a = '0;
        end
    end

    // Read port B: same structure as port A
    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if (fwd_b) begin
            rd_data_b = wr_data;
        end
        if (!rst_n || (rd_addr_b == ZERO_IDX)) begin
            rd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_32x64.sv
// ----------------------------------------------------------------------------
// tb_reg_file_32x64
// Directed bench for reg_file_32x64. Two instances share all inputs: one with
// write->read forwarding, one without, so forwarding behaviour can be compared
// side by side.
// ----------------------------------------------------------------------------
module tb_reg_file_32x64;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [4:0]       rd_addr_a;
    logic [4:0]       rd_addr_b;
    logic [WIDTH-1:0] ra1, rb1;   // BYPASS=1 instance
    logic [WIDTH-1:0] ra0, rb0;   // BYPASS=0 instance

    int checks;
    int failures;

    reg_file_32x64 #(.WIDTH(WIDTH), .ZERO_REG(31), .BYPASS(1'b1)) u_dut_byp (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (ra1),
        .rd_data_b (rb1)
    );

    reg_file_32x64 #(.WIDTH(WIDTH), .ZERO_REG(31), .BYPASS(1'b0)) u_dut_nobyp (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (ra0),
        .rd_data_b (rb0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a write for exactly one posedge; inputs change on negedges
    task automatic do_write(input logic [4:0] addr, input logic [WIDTH-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] pattern(input int i);
        logic [WIDTH-1:0] base;
        base = 64'h1111_1111_1111_1111;
        return WIDTH'(base * WIDTH'(i));
    endfunction

    initial begin
        logic [WIDTH-1:0] exp_v;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd6;

        // Reset state
        #2;
        chk("reset_a_byp",   ra1, '0);
        chk("reset_b_nobyp", rb0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: asynchronous reset pulse between edges
        do_write(5'd5, 64'hDEAD_BEEF_0000_0001);
        #1;
        chk("x5_written_byp",   ra1, 64'hDEAD_BEEF_0000_0001);
        chk("x5_written_nobyp", ra0, 64'hDEAD_BEEF_0000_0001);
        rst_n = 1'b0;
        #1;
        chk("x5_in_reset_byp",   ra1, '0);
        chk("x5_in_reset_nobyp", ra0, '0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            chk("post_reset_a", ra1, '0);
            chk("post_reset_b", rb0, '0);
        end

        // 2: fill X0..X30, sweep both ports over all addresses
        for (int i = 0; i < 31; i++) begin
            do_write(5'(i), pattern(i));
        end
        for (int i = 0; i < 32; i++) begin
            exp_v     = (i == 31) ? '0 : pattern(i);
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(i);
            #1;
            chk("sweep_a_byp",   ra1, exp_v);
            chk("sweep_b_byp",   rb1, exp_v);
            chk("sweep_a_nobyp", ra0, exp_v);
            chk("sweep_b_nobyp", rb0, exp_v);
        end

        // 3: writes to the zero register are dropped, even when forwarding
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = 5'd31;
        wr_data   = '1;
        rd_addr_a = 5'd31;
        rd_addr_b = 5'd30;
        #1;
        chk("xzr_no_forward", ra1, '0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("xzr_reads_zero_byp",   ra1, '0);
        chk("xzr_reads_zero_nobyp", ra0, '0);
        chk("x30_unchanged",        rb1, 64'h0000_0000_0000_000E & '0 | pattern(30));

        // 4: forwarding vs no forwarding on both ports
        do_write(5'd7, 64'h10);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 64'h20;
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd7;
        #1;
        chk("bypass_a_before_edge",   ra1, 64'h20);
        chk("bypass_b_before_edge",   rb1, 64'h20);
        chk("nobypass_a_before_edge", ra0, 64'h10);
        chk("nobypass_b_before_edge", rb0, 64'h10);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        chk("nobypass_a_after_edge", ra0, 64'h20);
        chk("bypass_a_after_edge",   ra1, 64'h20);

        // 5: wr_en low holds the register over several edges
        do_write(5'd3, 64'h33);
        @(negedge clk);
        wr_en     = 1'b0;
        wr_addr   = 5'd3;
        wr_data   = 64'hFF;
        rd_addr_a = 5'd3;
        #1;
        chk("wr_en_low_no_forward", ra1, 64'h33);
        repeat (4) @(posedge clk);
        #1;
        chk("wr_en_low_byp",   ra1, 64'h33);
        chk("wr_en_low_nobyp", ra0, 64'h33);

        // 6: a posedge under reset performs no write and no forwarding
        do_write(5'd9, 64'h5A);
        @(negedge clk);
        rst_n     = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 64'h99;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd3;
        #1;
        chk("reset_suppresses_bypass", ra1, '0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("x9_no_write_in_reset_byp",   ra1, '0);
        chk("x9_no_write_in_reset_nobyp", ra0, '0);
        chk("x3_cleared_by_reset",        rb1, '0);

        // First write after release lands on the next edge
        do_write(5'd9, 64'h99);
        #1;
        chk("x9_write_after_release", ra0, 64'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
